// File: rtl/zx_vram_pkg.sv
// zx_vram_pkg: shared VRAM write entry type and screen bank numbers
package zx_vram_pkg;
  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } vram_wr_t;
  localparam logic [2:0] BANK_SCR0 = 3'd5;
  localparam logic [2:0] BANK_SCR1 = 3'd7;
endpackage

// File: rtl/vram_writer_if.sv
// vram_writer_if: CPU snoop bus in, VRAM write port and status out
interface vram_writer_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W = $clog2(FIFO_DEPTH) + 1
);
  logic [15:0]      addr;
  logic [7:0]       cpu_dout;
  logic             nMREQ;
  logic             nWR;
  logic             nRFSH;
  logic             m128;
  logic [2:0]       page_ram;
  logic             wr_slot;
  logic             vram_we;
  logic [14:0]      vram_waddr;
  logic [7:0]       vram_wdata;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  modport slave (
    input  addr, cpu_dout, nMREQ, nWR, nRFSH, m128, page_ram, wr_slot,
    output vram_we, vram_waddr, vram_wdata, fifo_level, overflow
  );
  modport master (
    output addr, cpu_dout, nMREQ, nWR, nRFSH, m128, page_ram, wr_slot,
    input  vram_we, vram_waddr, vram_wdata, fifo_level, overflow
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: sync FIFO of VRAM write entries with a tail data overwrite port
module vram_wr_fifo
  import zx_vram_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  vram_wr_t         din,
  input  logic             tail_we,
  input  logic [7:0]       tail_data,
  output vram_wr_t         head,
  output vram_wr_t         tail,
  output logic             full,
  output logic [LVL_W-1:0] level
);
  localparam int PW = LVL_W - 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  vram_wr_t mem [DEPTH];
  logic [PW-1:0] wp, rp, tp;
  logic push_ok, pop_ok;
  assign full    = level == LVL_W'(DEPTH);
  assign pop_ok  = pop & (level != '0);
  assign push_ok = push & (~full | pop_ok);
  assign tp      = wp - ONE;
  assign head    = mem[rp];
  assign tail    = mem[tp];
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wp] <= din;
    if (tail_we) mem[tp].data <= tail_data;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push_ok) wp <= wp + ONE;
      if (pop_ok) rp <= rp + ONE;
      level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end
endmodule

// File: rtl/vram_writer.sv
// vram_writer: snoops Z80 screen writes into a FIFO drained on VRAM write slots
// Optional macro VRAM_WRITER_COALESCE_EN merges a write into a matching tail entry.
module vram_writer
  import zx_vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input logic          clk_sys,
  input logic          reset,
  vram_writer_if.slave bus
);
`ifdef VRAM_WRITER_COALESCE_EN
  localparam bit COAL_EN = 1'b1;
`else
  localparam bit COAL_EN = 1'b0;
`endif
  logic wr, old_wr, hit, cap, pop, push, coal, full;
  logic [14:0] waddr;
  logic [LVL_W-1:0] level;
  vram_wr_t head, tail;
  assign wr    = ~bus.nMREQ & ~bus.nWR & bus.nRFSH;
  assign hit   = (bus.addr[15:14] == 2'b01) |
                 ((bus.addr[15:14] == 2'b11) & bus.m128 &
                  ((bus.page_ram == BANK_SCR0) | (bus.page_ram == BANK_SCR1)));
  assign waddr = {(bus.addr[15:14] == 2'b11) & (bus.page_ram == BANK_SCR1), bus.addr[13:0]};
  assign cap   = wr & ~old_wr & hit;
  assign pop   = bus.wr_slot & (level != '0);
  // A tail that is also the head being popped cannot be merged into
  assign coal  = COAL_EN & cap & (level != '0) & (tail.addr == waddr) &
                 ~(pop & (level == LVL_W'(1)));
  assign push  = cap & ~coal;
  vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      ('{addr: waddr, data: bus.cpu_dout}),
    .tail_we  (coal),
    .tail_data(bus.cpu_dout),
    .head     (head),
    .tail     (tail),
    .full     (full),
    .level    (level)
  );
  assign bus.fifo_level = level;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_wr         <= 1'b0;
      bus.vram_we    <= 1'b0;
      bus.vram_waddr <= '0;
      bus.vram_wdata <= '0;
      bus.overflow   <= 1'b0;
    end else begin
      old_wr      <= wr;
      bus.vram_we <= pop;
      if (pop) begin
        bus.vram_waddr <= head.addr;
        bus.vram_wdata <= head.data;
      end
      if (push & full & ~pop) bus.overflow <= 1'b1;
    end
  end
endmodule
